round_robin_mux_arbiter: RTL and testbench

ROUND_ROBIN_MUX_ARBITER -- requirements
Module: round_robin_mux_arbiter

---
 rtl/round_robin_mux_arbiter.sv | 123 ++++++++++++
 tb/tb_round_robin_mux_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_mux_arbiter.sv
// Purpose: four-way round-robin arbiter that muxes the owner's data word onto a
//          single valid/ready output, with bounded bursts per grant.
// Latency: one cycle from request to grant; one idle cycle after every release.
// Backpressure: out_ready low holds the owner, beat count and sel; no ack is issued.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   req[3:0]           per-requester request
//   data[4*WIDTH-1:0]  requester i word at [i*WIDTH +: WIDTH]
//   out_ready          consumer accepts the word this cycle
//   out_valid/out_data word of the current owner (data is 0 while idle)
//   sel, grant         registered owner address and one-hot owner (0 when idle)
//   ack[3:0]           one-hot, set in the cycle requester i's word is transferred
module round_robin_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         sel,
    output logic [3:0]         grant,
    output logic [3:0]         ack
);

    // Four bits cover the whole legal burst range 1..15.
    localparam int             CW      = 4;
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    grant_q, grant_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]    winner;
    logic [1:0]    idx;
    logic          xfer;

    // Rotating priority: scan last+1, last+2, last+3, last. Walking the offsets
    // from farthest to nearest lets the nearest set request overwrite the rest.
    always_comb begin
        winner = last_q;
        idx    = last_q;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + k[1:0];
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign out_valid = (state_q == GRANT) && req[sel_q];
    assign out_data  = (state_q == GRANT) ? data[sel_q*WIDTH +: WIDTH] : '0;

    // A reset cycle never transfers, even if the owner is ready mid-burst.
    assign xfer = out_valid && out_ready && !reset;
    assign ack  = xfer ? (4'b0001 << sel_q) : 4'b0000;

    assign sel   = sel_q;
    assign grant = grant_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    grant_d = 4'b0001 << winner;
                    count_d = '0;
                end
            end
            GRANT: begin
                // Release when the owner withdraws or its burst is used up;
                // the owner becomes lowest priority for the next arbitration.
                if (!req[sel_q] || (xfer && (count_q + 4'd1 == MAX_CNT))) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    last_d  = sel_q;
                    count_d = '0;
                end else if (xfer) begin
                    count_d = count_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            grant_q <= 4'b0000;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
module tb_round_robin_mux_arbiter;

    localparam logic [31:0] DATA = {8'h13, 8'hA5, 8'h11, 8'h10};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  sel;
    logic [3:0]  grant;
    logic [3:0]  ack;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [3:0] req;
        logic       rdy;
        logic       rst;
    } stim_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] ack;
        logic [7:0] dat;
        logic       vld;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    round_robin_mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] word(input int i);
        logic [31:0] d;
        d = DATA;
        return d[i*8 +: 8];
    endfunction

    // Queue one cycle of stimulus together with the outputs it must produce.
    task automatic step(input logic [3:0] rq, input logic rdy, input logic rst,
                        input logic [3:0] g, input logic [3:0] a,
                        input logic [7:0] d, input logic v);
        stim_t s;
        exp_t  e;
        s = '{req: rq, rdy: rdy, rst: rst};
        e = '{grant: g, ack: a, dat: d, vld: v};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // Cycle invariants checked throughout the run.
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ((ack & (ack - 4'd1)) !== 4'b0000) begin
                n_bad++; $display("FAIL inv_ack_onehot: ack=%b required one-hot or zero", ack);
            end
            n_cmp++;
            if (ack !== 4'b0000 && !(out_valid === 1'b1 && out_ready === 1'b1)) begin
                n_bad++; $display("FAIL inv_ack_handshake: ack=%b out_valid=%b out_ready=%b", ack, out_valid, out_ready);
            end
            n_cmp++;
            if (grant === 4'b0000 && ack !== 4'b0000) begin
                n_bad++; $display("FAIL inv_idle_ack: ack=%b required 0000 while idle", ack);
            end
            if (grant !== 4'b0000) begin
                n_cmp++;
                if (grant !== (4'b0001 << sel)) begin
                    n_bad++; $display("FAIL inv_grant_sel: grant=%b sel=%0d", grant, sel);
                end
            end
        end
    end

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        reset = 1'b1; req = 4'b1111; out_ready = 1'b1; data = DATA;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        // Reset held with all requests up: nothing may be granted.
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0);
        for (int c = 0; stim_q.size() != 0; c++) begin
            s = stim_q.pop_front();
            req = s.req; out_ready = s.rdy; reset = s.rst;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL reset_grant c%0d: got %b want %b", c, grant, e.grant); end
            n_cmp++; if (ack !== e.ack) begin n_bad++; $display("FAIL reset_ack c%0d: got %b want %b", c, ack, e.ack); end
            n_cmp++; if (out_data !== e.dat) begin n_bad++; $display("FAIL reset_data c%0d: got %h want %h", c, out_data, e.dat); end
            n_cmp++; if (out_valid !== e.vld) begin n_bad++; $display("FAIL reset_valid c%0d: got %b want %b", c, out_valid, e.vld); end
            n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel c%0d: got %0d want 0", c, sel); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rotation();
        stim_t s;
        exp_t  e;
        int    owners[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        foreach (owners[k]) begin
            step(4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0);
            for (int b = 0; b < 4; b++) begin
                step(4'b1111, 1'b1, 1'b0, 4'b0001 << owners[k], 4'b0001 << owners[k],
                     word(owners[k]), 1'b1);
            end
        end
        for (int c = 0; stim_q.size() != 0; c++) begin
            s = stim_q.pop_front();
            req = s.req; out_ready = s.rdy; reset = s.rst;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL rot_grant c%0d: got %b want %b", c, grant, e.grant); end
            n_cmp++; if (ack !== e.ack) begin n_bad++; $display("FAIL rot_ack c%0d: got %b want %b", c, ack, e.ack); end
            n_cmp++; if (out_data !== e.dat) begin n_bad++; $display("FAIL rot_data c%0d: got %h want %h", c, out_data, e.dat); end
            n_cmp++; if (out_valid !== e.vld) begin n_bad++; $display("FAIL rot_valid c%0d: got %b want %b", c, out_valid, e.vld); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        stim_t s;
        exp_t  e;
        apply_reset();
        step(4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0);
        step(4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0100, 8'hA5, 1'b1);
        // Owner withdraws with the consumer ready: no transfer, then release.
        step(4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0000, 8'hA5, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0);
        for (int c = 0; stim_q.size() != 0; c++) begin
            s = stim_q.pop_front();
            req = s.req; out_ready = s.rdy; reset = s.rst;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL single_grant c%0d: got %b want %b", c, grant, e.grant); end
            n_cmp++; if (ack !== e.ack) begin n_bad++; $display("FAIL single_ack c%0d: got %b want %b", c, ack, e.ack); end
            n_cmp++; if (out_data !== e.dat) begin n_bad++; $display("FAIL single_data c%0d: got %h want %h", c, out_data, e.dat); end
            n_cmp++; if (out_valid !== e.vld) begin n_bad++; $display("FAIL single_valid c%0d: got %b want %b", c, out_valid, e.vld); end
            if (c == 1) begin
                n_cmp++; if (sel !== 2'd2) begin n_bad++; $display("FAIL single_sel: got %0d want 2", sel); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        stim_t s;
        exp_t  e;
        apply_reset();
        step(4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 8'h11, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0010, 8'h11, 1'b1);
        // last=1 after release, so requester 2 beats requester 1.
        step(4'b0110, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0);
        step(4'b0110, 1'b1, 1'b0, 4'b0100, 4'b0100, 8'hA5, 1'b1);
        for (int c = 0; stim_q.size() != 0; c++) begin
            s = stim_q.pop_front();
            req = s.req; out_ready = s.rdy; reset = s.rst;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL stall_grant c%0d: got %b want %b", c, grant, e.grant); end
            n_cmp++; if (ack !== e.ack) begin n_bad++; $display("FAIL stall_ack c%0d: got %b want %b", c, ack, e.ack); end
            n_cmp++; if (out_data !== e.dat) begin n_bad++; $display("FAIL stall_data c%0d: got %h want %h", c, out_data, e.dat); end
            n_cmp++; if (out_valid !== e.vld) begin n_bad++; $display("FAIL stall_valid c%0d: got %b want %b", c, out_valid, e.vld); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drop();
        stim_t s;
        exp_t  e;
        apply_reset();
        step(4'b1001, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0);
        step(4'b1001, 1'b1, 1'b0, 4'b0001, 4'b0001, 8'h10, 1'b1);
        step(4'b1001, 1'b1, 1'b0, 4'b0001, 4'b0001, 8'h10, 1'b1);
        step(4'b1000, 1'b1, 1'b0, 4'b0001, 4'b0000, 8'h10, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 4'b1000, 4'b1000, 8'h13, 1'b1);
        for (int c = 0; stim_q.size() != 0; c++) begin
            s = stim_q.pop_front();
            req = s.req; out_ready = s.rdy; reset = s.rst;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL drop_grant c%0d: got %b want %b", c, grant, e.grant); end
            n_cmp++; if (ack !== e.ack) begin n_bad++; $display("FAIL drop_ack c%0d: got %b want %b", c, ack, e.ack); end
            n_cmp++; if (out_data !== e.dat) begin n_bad++; $display("FAIL drop_data c%0d: got %h want %h", c, out_data, e.dat); end
            n_cmp++; if (out_valid !== e.vld) begin n_bad++; $display("FAIL drop_valid c%0d: got %b want %b", c, out_valid, e.vld); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_burst();
        stim_t s;
        exp_t  e;
        apply_reset();
        step(4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0);
        step(4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0100, 8'hA5, 1'b1);
        step(4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0100, 8'hA5, 1'b1);
        // Reset cycle: owner still valid and ready, but no ack may be issued.
        step(4'b0101, 1'b1, 1'b1, 4'b0100, 4'b0000, 8'hA5, 1'b1);
        step(4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0);
        step(4'b0101, 1'b1, 1'b0, 4'b0001, 4'b0001, 8'h10, 1'b1);
        for (int c = 0; stim_q.size() != 0; c++) begin
            s = stim_q.pop_front();
            req = s.req; out_ready = s.rdy; reset = s.rst;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++; if (grant !== e.grant) begin n_bad++; $display("FAIL midrst_grant c%0d: got %b want %b", c, grant, e.grant); end
            n_cmp++; if (ack !== e.ack) begin n_bad++; $display("FAIL midrst_ack c%0d: got %b want %b", c, ack, e.ack); end
            n_cmp++; if (out_data !== e.dat) begin n_bad++; $display("FAIL midrst_data c%0d: got %h want %h", c, out_data, e.dat); end
            n_cmp++; if (out_valid !== e.vld) begin n_bad++; $display("FAIL midrst_valid c%0d: got %b want %b", c, out_valid, e.vld); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; req = 4'b0000; out_ready = 1'b0; data = DATA;
        test_reset();
        test_rotation();
        test_single();
        test_stall();
        test_drop();
        test_reset_mid_burst();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
